// File: rtl/innerproduct_pkg.sv
// Shared types and helpers for the streaming inner-product engine.
package innerproduct_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;

    localparam logic [40:0] DEFAULT_SKIP_MASK = 41'h2;

    function automatic int unsigned beats(input int unsigned nfeat, input int unsigned lanes);
        return (nfeat + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational per-beat multiply, mask and sum across LANES lanes.
module mac_lane_sum #(
    parameter int unsigned DW = 32,
    parameter int unsigned NFEAT = 41,
    parameter int unsigned LANES = 4,
    parameter int unsigned IW = 6,
    parameter logic [NFEAT-1:0] SKIP_MASK = '0
) (
    input  logic [LANES*DW-1:0] x,
    input  logic [LANES*DW-1:0] theta,
    input  logic [IW-1:0]       base,
    output logic [DW-1:0]       sum
);

    logic [31:0]   idx;
    logic          keep;
    logic [DW-1:0] term;

    always_comb begin
        sum  = '0;
        idx  = '0;
        keep = 1'b0;
        term = '0;
        for (int k = 0; k < LANES; k++) begin
            idx  = 32'(base) + k;
            // Lanes past the last feature never match j, so they stay dropped.
            keep = 1'b0;
            for (int j = 0; j < NFEAT; j++) begin
                if (idx == j) keep = !SKIP_MASK[j];
            end
            if (idx == 0) begin
                term = theta[k*DW +: DW];
            end else begin
                term = x[k*DW +: DW] * theta[k*DW +: DW];
            end
            if (keep) sum = sum + term;
        end
    end

endmodule

// File: rtl/innerproduct_stream.sv
// Time-multiplexed inner product: hprime = THETA0 + sum(x[i]*THETA[i]) over a beat stream.
module innerproduct_stream
    import innerproduct_pkg::*;
#(
    parameter int unsigned      DW        = 32,
    parameter int unsigned      NFEAT     = 41,
    parameter int unsigned      LANES     = 4,
    parameter logic [NFEAT-1:0] SKIP_MASK = NFEAT'(DEFAULT_SKIP_MASK),
    parameter int unsigned      AW        = $clog2(NFEAT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                theta_we,
    input  logic [AW-1:0]       theta_addr,
    input  logic [DW-1:0]       theta_wdata,
    output logic                theta_busy,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [LANES*DW-1:0] s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DW-1:0]       m_hprime,
    output logic                m_err
);

    localparam int unsigned BEATS = beats(NFEAT, LANES);
    localparam int unsigned MW    = BEATS * LANES;
    localparam int unsigned IW    = (MW > 1) ? $clog2(MW) : 1;
    localparam int unsigned CW    = $clog2(BEATS + 1);

    state_e        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;
    logic          init_q;
    logic [DW-1:0] theta_q [NFEAT];

    logic [LANES*DW-1:0] theta_slice;
    logic [IW-1:0]       base;
    logic [DW-1:0]       beat_sum;
    logic                s_fire;
    logic                final_slot;
    logic                term_beat;

    assign base = IW'(32'(beat_cnt_q) * LANES);

    always_comb begin
        theta_slice = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < NFEAT; j++) begin
                if (32'(base) + k == j) theta_slice[k*DW +: DW] = theta_q[j];
            end
        end
    end

    mac_lane_sum #(
        .DW        (DW),
        .NFEAT     (NFEAT),
        .LANES     (LANES),
        .IW        (IW),
        .SKIP_MASK (SKIP_MASK)
    ) u_mac (
        .x     (s_data),
        .theta (theta_slice),
        .base  (base),
        .sum   (beat_sum)
    );

    // init_q keeps s_ready low during reset and the first cycle after it.
    assign s_ready    = init_q && (state_q != OUT);
    assign s_fire     = s_valid && s_ready;
    assign final_slot = (32'(beat_cnt_q) == BEATS - 1);
    assign term_beat  = s_last || final_slot;
    assign theta_busy = (state_q != IDLE);
    assign m_valid    = (state_q == OUT);
    assign m_hprime   = acc_q;
    assign m_err      = err_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            // acc is zero in IDLE, so the first beat seeds it through the same add.
            IDLE, ACCUM: begin
                if (s_fire) begin
                    acc_d      = acc_q + beat_sum;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (term_beat) begin
                        state_d = OUT;
                        err_d   = !(s_last && final_slot);
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d    = IDLE;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            init_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NFEAT; j++) theta_q[j] <= '0;
        end else if (theta_we && (state_q == IDLE)) begin
            for (int j = 0; j < NFEAT; j++) begin
                if (32'(theta_addr) == j) theta_q[j] <= theta_wdata;
            end
        end
    end

endmodule
